// File: rtl/cond_flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_flags_unit
// Purpose  : Banked NZCV condition-flag registers with per-flag write
//            masking, a per-bank save/restore stack for exception entry and
//            return, and ARM 4-bit condition-code evaluation.
// Ports    : clk, reset (async, active-low)
//            bank_sel           - bank used by every read/write/push/pop
//            wr_en, wr_mask     - flag write strobe and {C,V,Z,N} enables
//            negative, zero, overflow, carry_out - new ALU flags
//            push, pop, err_clr - stack save / restore / error clear
//            cond               - condition code to evaluate
//            q                  - selected bank flags {C,V,Z,N}
//            cond_pass          - condition holds
//            stack_full, stack_empty, stack_cnt, stack_err - stack status
// Config   : COND_FLAGS_BYPASS_EN - when defined, cond_pass sees the
//            same-cycle masked write; otherwise registered flags only.
// Revision : 1.0 - initial release
// ============================================================================
module cond_flags_unit #(
    parameter  int NUM_BANKS   = 2,
    parameter  int STACK_DEPTH = 4,
    localparam int BW          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] bank_sel,
    input  logic          wr_en,
    input  logic [3:0]    wr_mask,
    input  logic          negative,
    input  logic          zero,
    input  logic          overflow,
    input  logic          carry_out,
    input  logic          push,
    input  logic          pop,
    input  logic          err_clr,
    input  logic [3:0]    cond,
    output logic [3:0]    q,
    output logic          cond_pass,
    output logic          stack_full,
    output logic          stack_empty,
    output logic [CW-1:0] stack_cnt,
    output logic          stack_err
);

    // Arrays are sized to powers of two so every index is exactly as wide
    // as the selector driving it; the extra entries are never written.
    localparam int NB = 2 ** BW;
    localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SD = 2 ** SW;

    logic [3:0]    flags_q [NB];
    logic [3:0]    flags_d [NB];
    logic [CW-1:0] cnt_q   [NB];
    logic [CW-1:0] cnt_d   [NB];
    logic [NB-1:0] err_q;
    logic [NB-1:0] err_d;
    logic [NB-1:0] push_ok;
    logic [3:0]    stack_q [NB][SD];

    logic          bank_ok;
    logic [BW-1:0] rd_idx;
    logic [3:0]    new_flags;
    logic [3:0]    eval_flags;

    assign new_flags = {carry_out, overflow, zero, negative};

    // Out-of-range selects only exist when NUM_BANKS is not a power of two.
    generate
        if (NB == NUM_BANKS) begin : g_pow2_banks
            assign bank_ok = 1'b1;
        end else begin : g_npow2_banks
            assign bank_ok = ({{(32-BW){1'b0}}, bank_sel} < 32'(NUM_BANKS));
        end
    endgenerate

    assign rd_idx = bank_ok ? bank_sel : '0;

    // ------------------------------------------------------------------
    // Next-state logic per bank
    // ------------------------------------------------------------------
    always_comb begin
        logic          sel;
        logic          full;
        logic          empty;
        logic          pop_ok;
        logic          err_ev;
        logic [SW-1:0] top;
        for (int b = 0; b < NB; b++) begin
            sel    = bank_ok && (bank_sel == BW'(b));
            full   = (cnt_q[b] == CW'(STACK_DEPTH));
            empty  = (cnt_q[b] == '0);
            top    = SW'(cnt_q[b] - CW'(1));
            pop_ok = sel && pop && !push && !empty;
            push_ok[b] = sel && push && !pop && !full;
            err_ev = sel && ((push && pop) || (push && full) || (pop && empty));

            flags_d[b] = flags_q[b];
            cnt_d[b]   = cnt_q[b];
            err_d[b]   = err_q[b];

            // A successful pop restores all four bits and beats any write.
            if (pop_ok) begin
                flags_d[b] = stack_q[b][top];
            end else if (sel && wr_en) begin
                flags_d[b] = (flags_q[b] & ~wr_mask) | (new_flags & wr_mask);
            end

            if (push_ok[b]) begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end else if (pop_ok) begin
                cnt_d[b] = cnt_q[b] - CW'(1);
            end

            // A fresh error in the same cycle as err_clr keeps the flag set.
            if (err_ev) begin
                err_d[b] = 1'b1;
            end else if (sel && err_clr) begin
                err_d[b] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NB; b++) begin
                flags_q[b] <= '0;
                cnt_q[b]   <= '0;
            end
            err_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                flags_q[b] <= flags_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            err_q <= err_d;
        end
    end

    // Stack storage needs no reset: occupancy alone defines valid entries.
    // The pushed value is the registered flags, i.e. the pre-write value.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (push_ok[b]) begin
                stack_q[b][cnt_q[b][SW-1:0]] <= flags_q[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign q           = flags_q[rd_idx];
    assign stack_cnt   = cnt_q[rd_idx];
    assign stack_full  = (cnt_q[rd_idx] == CW'(STACK_DEPTH));
    assign stack_empty = (cnt_q[rd_idx] == '0);
    assign stack_err   = err_q[rd_idx];

`ifdef COND_FLAGS_BYPASS_EN
    // Merge the in-flight masked write so a compare and its dependent
    // branch resolve in the same cycle.
    assign eval_flags = (bank_ok && wr_en)
                      ? ((flags_q[rd_idx] & ~wr_mask) | (new_flags & wr_mask))
                      : flags_q[rd_idx];
`else
    assign eval_flags = flags_q[rd_idx];
`endif

    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
        logic n;
        logic z;
        logic v;
        logic c;
        logic r;
        n = f[0];
        z = f[1];
        v = f[2];
        c = f[3];
        case (code)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c && !z;
            4'h9:    r = !c || z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z && (n == v);
            4'hD:    r = z || (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign cond_pass = cond_eval(cond, eval_flags);

endmodule
`default_nettype wire

// File: tb/tb_cond_flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_flags_unit
// Purpose  : Directed self-checking bench for cond_flags_unit (2 banks,
//            4-deep stacks). Inputs change 1 ns after the rising edge and
//            outputs are sampled mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_flags_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] bank_sel;
    logic       wr_en;
    logic [3:0] wr_mask;
    logic       negative, zero, overflow, carry_out;
    logic       push, pop, err_clr;
    logic [3:0] cond;
    logic [3:0] q;
    logic       cond_pass;
    logic       stack_full, stack_empty;
    logic [2:0] stack_cnt;
    logic       stack_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cond_flags_unit #(.NUM_BANKS(2), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bank_sel(bank_sel),
        .wr_en(wr_en), .wr_mask(wr_mask),
        .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
        .push(push), .pop(pop), .err_clr(err_clr), .cond(cond),
        .q(q), .cond_pass(cond_pass),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_cnt(stack_cnt), .stack_err(stack_err)
    );

    task automatic idle();
        wr_en = 0; wr_mask = 4'b0000; push = 0; pop = 0; err_clr = 0;
        {carry_out, overflow, zero, negative} = 4'b0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // f is {C,V,Z,N}
    task automatic set_flags(input logic [3:0] m, input logic [3:0] f);
        wr_en = 1; wr_mask = m;
        {carry_out, overflow, zero, negative} = f;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        idle(); bank_sel = 0; cond = 4'h0;
        reset = 0;
        #3;
        tick();
        checks++; if (q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", q); end
        checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", stack_empty, stack_full); end
        checks++; if (stack_cnt !== 3'd0 || stack_err !== 1'b0) begin failures++; $display("FAIL reset_cnt_err got=%0d/%b exp=0/0", stack_cnt, stack_err); end
        checks++; if (cond_pass !== 1'b0) begin failures++; $display("FAIL reset_eq got=%b exp=0", cond_pass); end
        cond = 4'h1; #1;
        checks++; if (cond_pass !== 1'b1) begin failures++; $display("FAIL reset_ne got=%b exp=1", cond_pass); end
        reset = 1;
        tick();
    endtask

    task automatic test_write();
        logic [15:0] exp_tbl;
        // Flags N=1 Z=0 V=1 C=0: pass bits for conds F..0
        exp_tbl = 16'hD65A;
        set_flags(4'b1111, 4'b0101);
        tick();
        idle();
        #1;
        checks++; if (q !== 4'b0101) begin failures++; $display("FAIL write_q got=%b exp=0101", q); end
        for (int c = 0; c < 16; c++) begin
            cond = 4'(c); #1;
            checks++;
            if (cond_pass !== exp_tbl[c]) begin
                failures++; $display("FAIL cond_%0h got=%b exp=%b", c, cond_pass, exp_tbl[c]);
            end
        end
    endtask

    task automatic test_masked_write();
        set_flags(4'b1111, 4'b1111);
        tick();
        set_flags(4'b0010, 4'b0000);
        tick();
        idle(); #1;
        checks++; if (q !== 4'b1101) begin failures++; $display("FAIL masked_q got=%b exp=1101", q); end
        bank_sel = 1; #1;
        checks++; if (q !== 4'b0000) begin failures++; $display("FAIL bank1_q got=%b exp=0000", q); end
        set_flags(4'b1111, 4'b1001);
        tick();
        idle(); #1;
        checks++; if (q !== 4'b1001) begin failures++; $display("FAIL bank1_write got=%b exp=1001", q); end
        bank_sel = 0; #1;
        checks++; if (q !== 4'b1101) begin failures++; $display("FAIL bank0_isolated got=%b exp=1101", q); end
    endtask

    task automatic test_bypass();
        do_reset();
        bank_sel = 0; cond = 4'h0;
        set_flags(4'b0010, 4'b0010);
        #1;
`ifdef COND_FLAGS_BYPASS_EN
        checks++; if (cond_pass !== 1'b1) begin failures++; $display("FAIL bypass_same got=%b exp=1", cond_pass); end
`else
        checks++; if (cond_pass !== 1'b0) begin failures++; $display("FAIL bypass_same got=%b exp=0", cond_pass); end
`endif
        checks++; if (q !== 4'b0000) begin failures++; $display("FAIL bypass_q_same got=%b exp=0000", q); end
        tick();
        idle(); #1;
        checks++; if (cond_pass !== 1'b1 || q !== 4'b0010) begin failures++; $display("FAIL bypass_next got=%b/%b exp=1/0010", cond_pass, q); end
    endtask

    task automatic test_stack();
        logic [3:0] vals [4];
        vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;
        do_reset();
        bank_sel = 0;
        for (int i = 0; i < 4; i++) begin
            set_flags(4'b1111, vals[i]);
            tick();
            idle(); push = 1;
            tick();
            idle(); #1;
            checks++; if (stack_cnt !== 3'(i + 1)) begin failures++; $display("FAIL push_cnt_%0d got=%0d exp=%0d", i, stack_cnt, i + 1); end
        end
        checks++; if (stack_full !== 1'b1 || stack_empty !== 1'b0) begin failures++; $display("FAIL full got=%b%b exp=10", stack_full, stack_empty); end
        bank_sel = 1; #1;
        checks++; if (stack_cnt !== 3'd0 || stack_empty !== 1'b1) begin failures++; $display("FAIL bank1_stack got=%0d/%b exp=0/1", stack_cnt, stack_empty); end
        bank_sel = 0;
        push = 1;
        tick();
        idle(); #1;
        checks++; if (stack_err !== 1'b1 || stack_cnt !== 3'd4) begin failures++; $display("FAIL overflow got=%b/%0d exp=1/4", stack_err, stack_cnt); end
        // Overwrite live flags so the first restore is distinguishable
        set_flags(4'b1111, 4'b1111);
        tick();
        for (int i = 3; i >= 0; i--) begin
            idle(); pop = 1;
            tick();
            idle(); #1;
            checks++; if (q !== vals[i] || stack_cnt !== 3'(i)) begin failures++; $display("FAIL pop_%0d got=%b/%0d exp=%b/%0d", i, q, stack_cnt, vals[i], i); end
        end
        checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL empty got=%b exp=1", stack_empty); end
        pop = 1;
        tick();
        idle(); #1;
        checks++; if (q !== 4'b0001 || stack_err !== 1'b1 || stack_cnt !== 3'd0) begin failures++; $display("FAIL underflow got=%b/%b/%0d exp=0001/1/0", q, stack_err, stack_cnt); end
        err_clr = 1;
        tick();
        idle(); #1;
        checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", stack_err); end
    endtask

    task automatic test_conflicts();
        do_reset();
        bank_sel = 0;
        set_flags(4'b1111, 4'b0110);
        tick();
        // Push with concurrent write: stack gets pre-write value 0110
        idle(); push = 1; set_flags(4'b1111, 4'b1001);
        tick();
        idle(); #1;
        checks++; if (q !== 4'b1001 || stack_cnt !== 3'd1) begin failures++; $display("FAIL push_write got=%b/%0d exp=1001/1", q, stack_cnt); end
        push = 1; pop = 1;
        tick();
        idle(); #1;
        checks++; if (stack_cnt !== 3'd1 || stack_err !== 1'b1) begin failures++; $display("FAIL push_pop got=%0d/%b exp=1/1", stack_cnt, stack_err); end
        push = 1; pop = 1; err_clr = 1;
        tick();
        idle(); #1;
        checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL clr_vs_err got=%b exp=1", stack_err); end
        err_clr = 1;
        tick();
        idle();
        pop = 1; set_flags(4'b1111, 4'b1111);
        tick();
        idle(); #1;
        checks++; if (q !== 4'b0110 || stack_cnt !== 3'd0 || stack_err !== 1'b0) begin failures++; $display("FAIL pop_wins got=%b/%0d/%b exp=0110/0/0", q, stack_cnt, stack_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bank_sel = 0;
        set_flags(4'b1111, 4'b1010);
        tick();
        idle(); push = 1;
        tick();
        tick();
        idle(); push = 1; #1;
        checks++; if (stack_cnt !== 3'd2 || q !== 4'b1010) begin failures++; $display("FAIL pre_reset got=%0d/%b exp=2/1010", stack_cnt, q); end
        reset = 0;
        #1;
        checks++; if (stack_cnt !== 3'd0 || q !== 4'b0000 || stack_empty !== 1'b1) begin failures++; $display("FAIL async_reset got=%0d/%b/%b exp=0/0000/1", stack_cnt, q, stack_empty); end
        idle();
        #1 reset = 1;
        tick();
        #1;
        checks++; if (stack_cnt !== 3'd0 || q !== 4'b0000) begin failures++; $display("FAIL post_reset got=%0d/%b exp=0/0000", stack_cnt, q); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_masked_write();
        test_bypass();
        test_stack();
        test_conflicts();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
